// File: rtl/pc_sequencer_if.sv
// Instruction-memory fetch channel: request handshake plus response data.
`timescale 1ns/1ps
interface pc_sequencer_if;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;

   modport master (
      output imem_req_valid,
      output imem_addr,
      input  imem_req_ready,
      input  imem_rsp_valid,
      input  imem_rsp_data
   );

   modport slave (
      input  imem_req_valid,
      input  imem_addr,
      output imem_req_ready,
      output imem_rsp_valid,
      output imem_rsp_data
   );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch / next-PC controller: owns the PC, sequences fetch -> response ->
// execute, computes redirect targets and traps on misaligned targets.
`timescale 1ns/1ps
module pc_sequencer #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
   input  logic          clk,
   input  logic          rst_n,
   pc_sequencer_if.master imem,
   output logic [31:0]   instr,
   output logic          instr_valid,
   input  logic          ex_done,
   input  logic          branch_taken,
   input  logic          jal,
   input  logic          jalr,
   input  logic [31:0]   imm,
   input  logic [31:0]   rs1,
   output logic          jalr_sel,
   output logic [31:0]   pc,
   output logic          trap,
   output logic [31:0]   mtval,
   output logic [31:0]   retired_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT,
      S_EXEC,
      S_TRAP
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] mtval_q, mtval_d;
   logic [31:0] retired_q, retired_d;
   logic [31:0] jalr_sum;
   logic [31:0] target;

   // Redirect target: jalr > jal > taken branch > sequential, all modulo 2^32
   always_comb begin
      jalr_sum = rs1 + imm;
      target   = pc_q + 32'd4;
      if (jalr) begin
         target = jalr_sum & 32'hFFFF_FFFE;
      end else if (jal || branch_taken) begin
         target = pc_q + imm;
      end
   end

   // State and architectural registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         pc_q      <= RESET_VECTOR;
         instr_q   <= '0;
         mtval_q   <= '0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         instr_q   <= instr_d;
         mtval_q   <= mtval_d;
         retired_q <= retired_d;
      end
   end

   // Next-state and register updates
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      instr_d   = instr_q;
      mtval_d   = mtval_q;
      retired_d = retired_q;
      case (state_q)
         S_IDLE:  state_d = S_FETCH;
         S_FETCH: if (imem.imem_req_ready) state_d = S_WAIT;
         S_WAIT: begin
            if (imem.imem_rsp_valid) begin
               instr_d = imem.imem_rsp_data;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            if (ex_done) begin
               if (target[1:0] == 2'b00) begin
                  pc_d      = target;
                  retired_d = retired_q + 32'd1;
                  state_d   = S_FETCH;
               end else begin
                  mtval_d = target;
                  pc_d    = TRAP_VECTOR;
                  state_d = S_TRAP;
               end
            end
         end
         S_TRAP:  state_d = S_FETCH;
         default: state_d = S_IDLE;
      endcase
   end

   // Moore-style outputs decoded from the current state
   always_comb begin
      imem.imem_req_valid = (state_q == S_FETCH);
      imem.imem_addr      = pc_q;
      instr_valid         = (state_q == S_EXEC);
      jalr_sel            = (state_q == S_EXEC) && jalr;
      trap                = (state_q == S_TRAP);
      instr               = instr_q;
      pc                  = pc_q;
      mtval               = mtval_q;
      retired_count       = retired_q;
   end

endmodule
